// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared instruction-word types, NOP encoding and fetch responder states
package riscv_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IMEM_IDLE,
    IMEM_WAIT,
    IMEM_RESP
  } imem_state_t;

endpackage

// File: rtl/imem_responder_if.sv
// rtl/imem_responder_if.sv - instruction-fetch request/response handshake bundle
interface imem_responder_if;
  import riscv_pkg::*;

  logic  req_valid;
  logic  req_ready;
  word_t req_addr;
  logic  resp_valid;
  logic  resp_ready;
  word_t resp_data;
  logic  resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/imem_responder_array.sv
// rtl/imem_responder_array.sv - program storage with sync write port and registered read
module imem_array
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  word_t         wdata,
  input  logic          re,
  input  logic [AW-1:0] ridx,
  output word_t         rdata
);

  word_t mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  // Same-index write in the read cycle returns the old word (read-before-write).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[ridx];
  end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fixed-latency instruction-fetch responder with side-band program load
module imem_responder
  import riscv_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                           clk,
  input  logic                           rst,
  imem_responder_if.slave                bus,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
  input  word_t                          ld_data
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  imem_state_t state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic        err_q;
  logic        accept;
  logic        addr_err;
  word_t       off;
  word_t       rdata;

  // Wrapping subtraction folds addresses below BASE_ADDR into the out-of-range check.
  assign off      = bus.req_addr - BASE_ADDR;
  assign addr_err = (off[1:0] != 2'b00) || (off >= SPAN);

  assign bus.req_ready = (state == IMEM_IDLE) && !ld_en && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  imem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (ld_en),
    .widx  (ld_idx),
    .wdata (ld_data),
    .re    (accept),
    .ridx  (off[AW+1:2]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IMEM_IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) err_q <= addr_err;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IMEM_IDLE: begin
        if (accept) begin
          cnt_nx   = 3'(LATENCY - 1);
          state_nx = (LATENCY == 1) ? IMEM_RESP : IMEM_WAIT;
        end
      end
      IMEM_WAIT: begin
        cnt_nx = cnt - 3'd1;
        if (cnt <= 3'd1) state_nx = IMEM_RESP;
      end
      IMEM_RESP: begin
        if (bus.resp_ready) state_nx = IMEM_IDLE;
      end
      default: state_nx = IMEM_IDLE;
    endcase
  end

  assign bus.resp_valid = (state == IMEM_RESP);
  assign bus.resp_err   = err_q;
  assign bus.resp_data  = err_q ? RV_NOP : rdata;

endmodule
